// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 8:1 mux: steps through all channels, holds each for SETTLE
// cycles, samples mux_y into a capture word and publishes it on data with a one-cycle done pulse.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] mask,
    output logic [2:0] sel,
    output logic       mux_en,
    input  logic       mux_y,
    output logic       busy,
    output logic       done,
    output logic [7:0] data
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    localparam logic [3:0] CntLast = 4'(SETTLE - 1);

    state_e     state_q;
    logic [7:0] mask_q;
    logic [2:0] ch_q;
    logic [3:0] cnt_q;
    logic [7:0] cap_q;
    logic [7:0] data_q;
    logic [2:0] sel_q;
    logic       mux_en_q;
    logic       busy_q;
    logic       done_q;

    logic       cap_hit;
    logic       last_ch;
    logic [2:0] ch_d;
    logic [7:0] cap_d;

    always_comb begin
        cap_hit      = (cnt_q == CntLast);
        last_ch      = (ch_q == 3'd7);
        ch_d         = ch_q + 3'd1;
        cap_d        = cap_q;
        cap_d[ch_q]  = mux_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mask_q   <= 8'h00;
            ch_q     <= 3'd0;
            cnt_q    <= 4'd0;
            cap_q    <= 8'h00;
            data_q   <= 8'h00;
            sel_q    <= 3'd0;
            mux_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        state_q  <= StScan;
                        mask_q   <= mask;
                        ch_q     <= 3'd0;
                        cnt_q    <= 4'd0;
                        cap_q    <= 8'h00;
                        sel_q    <= 3'd0;
                        mux_en_q <= mask[0];
                        busy_q   <= 1'b1;
                    end
                end
                StScan: begin
                    if (abort) begin
                        state_q  <= StIdle;
                        sel_q    <= 3'd0;
                        mux_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (cap_hit) begin
                        cnt_q <= 4'd0;
                        cap_q <= cap_d;
                        if (last_ch) begin
                            // Publish straight from cap_d so the channel-7 sample is included.
                            state_q  <= StDone;
                            data_q   <= cap_d;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            sel_q    <= 3'd0;
                            mux_en_q <= 1'b0;
                        end else begin
                            ch_q     <= ch_d;
                            sel_q    <= ch_d;
                            mux_en_q <= mask_q[ch_d];
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign sel    = sel_q;
    assign mux_en = mux_en_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign data   = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3) share stimulus; expected
// timing and data come from closed-form scan rules and a behavioural 8:1 mux.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] mask;
    logic [7:0] a;

    logic [2:0] sel1, sel3;
    logic       en1, en3, y1, y3, busy1, busy3, done1, done3;
    logic [7:0] data1, data3;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_data1;
    logic [7:0] exp_data3;

    always #5 clk = ~clk;

    // Compliant 8:1 mux: disabled output reads 0.
    assign y1 = en1 ? a[sel1] : 1'b0;
    assign y3 = en3 ? a[sel3] : 1'b0;

    mux_scan_ctrl #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mask(mask),
        .sel(sel1), .mux_en(en1), .mux_y(y1), .busy(busy1), .done(done1), .data(data1)
    );

    mux_scan_ctrl #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mask(mask),
        .sel(sel3), .mux_en(en3), .mux_y(y3), .busy(busy3), .done(done3), .data(data3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Captured word when the mux input jumps from 0 to all-ones at cycle chg.
    function automatic logic [7:0] exp_change(int s, int chg, logic [7:0] m);
        logic [7:0] r;
        for (int n = 0; n < 8; n++) r[n] = (((n + 1) * s) >= chg) ? m[n] : 1'b0;
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        start = 1'b0;
        abort = 1'b0;
        while ((busy1 || busy3 || done1 || done3) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (busy1 || busy3 || done1 || done3) begin
            errors++;
            $display("FAIL wait_idle: busy1=%b busy3=%b done1=%b done3=%b, required all 0",
                     busy1, busy3, done1, done3);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mask = 8'h00; a = 8'h00;
        #3;
        checks++;
        if ({sel1, en1, busy1, done1, data1} !== 14'h0) begin
            errors++;
            $display("FAIL reset_dut1: sel=%0d en=%b busy=%b done=%b data=%h, required all 0",
                     sel1, en1, busy1, done1, data1);
        end
        checks++;
        if ({sel3, en3, busy3, done3, data3} !== 14'h0) begin
            errors++;
            $display("FAIL reset_dut3: sel=%0d en=%b busy=%b done=%b data=%h, required all 0",
                     sel3, en3, busy3, done3, data3);
        end
        tick(); tick();
        rst_n = 1'b1;
        exp_data1 = 8'h00;
        exp_data3 = 8'h00;
        tick();
        checks++;
        if (busy1 !== 1'b0 || busy3 !== 1'b0 || done1 !== 1'b0 || done3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy1=%b busy3=%b done1=%b done3=%b, required 0",
                     busy1, busy3, done1, done3);
        end
    endtask

    task automatic test_basic_scan();
        mask = 8'hFF; a = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (sel1 !== 3'(c - 1) || en1 !== 1'b1 || busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL basic_step c=%0d: sel=%0d en=%b busy=%b done=%b, required %0d 1 1 0",
                         c, sel1, en1, busy1, done1, c - 1);
            end
            tick();
        end
        exp_data1 = a & mask;
        exp_data3 = a & mask;
        checks++;
        if (done1 !== 1'b1 || data1 !== exp_data1 || sel1 !== 3'd0 || en1 !== 1'b0
            || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b data=%h sel=%0d en=%b busy=%b, required 1 %h 0 0 0",
                     done1, data1, sel1, en1, busy1, exp_data1);
        end
        tick();
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: done=%b, required 0", done1);
        end
        wait_idle();
    endtask

    task automatic test_settle3();
        logic [2:0] ch;
        mask = 8'h0F; a = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            ch = 3'((c - 1) / 3);
            checks++;
            if (sel3 !== ch || en3 !== mask[ch] || busy3 !== 1'b1 || done3 !== 1'b0) begin
                errors++;
                $display("FAIL settle3_step c=%0d: sel=%0d en=%b busy=%b done=%b, required %0d %b 1 0",
                         c, sel3, en3, busy3, done3, ch, mask[ch]);
            end
            tick();
        end
        exp_data1 = a & mask;
        exp_data3 = a & mask;
        checks++;
        if (done3 !== 1'b1 || data3 !== exp_data3) begin
            errors++;
            $display("FAIL settle3_done: done=%b data=%h, required 1 %h", done3, data3, exp_data3);
        end
        checks++;
        if (data1 !== exp_data1) begin
            errors++;
            $display("FAIL settle3_dut1_data: data=%h, required %h", data1, exp_data1);
        end
        tick();
        checks++;
        if (done3 !== 1'b0) begin
            errors++;
            $display("FAIL settle3_done_width: done=%b, required 0", done3);
        end
        wait_idle();
    endtask

    task automatic test_abort();
        mask = 8'hFF; a = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || sel1 !== 3'd0 || en1 !== 1'b0 || done1 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy1=%b sel1=%0d en1=%b done1=%b busy3=%b, required all 0",
                     busy1, sel1, en1, done1, busy3);
        end
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (done1 !== 1'b0 || done3 !== 1'b0 || data1 !== exp_data1 || data3 !== exp_data3) begin
                errors++;
                $display("FAIL abort_hold i=%0d: done=%b/%b data=%h/%h, required 0/0 %h/%h",
                         i, done1, done3, data1, data3, exp_data1, exp_data3);
            end
            tick();
        end
    endtask

    task automatic test_abort_priority();
        mask = 8'hFF; a = 8'hFF;
        start = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
                errors++;
                $display("FAIL abort_priority i=%0d: busy1=%b busy3=%b, required 0 0",
                         i, busy1, busy3);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        mask = 8'hFF; a = 8'h96;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_data1 = 8'h00;
        exp_data3 = 8'h00;
        checks++;
        if ({sel1, en1, busy1, done1, data1, sel3, en3, busy3, done3, data3} !== 28'h0) begin
            errors++;
            $display("FAIL reset_mid: sel=%0d/%0d en=%b/%b busy=%b/%b done=%b/%b data=%h/%h, required 0",
                     sel1, sel3, en1, en3, busy1, busy3, done1, done3, data1, data3);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (done1 !== 1'b0 || done3 !== 1'b0 || busy1 !== 1'b0 || busy3 !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet i=%0d: done=%b/%b busy=%b/%b, required 0",
                         i, done1, done3, busy1, busy3);
            end
        end
        a = 8'h69;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            checks++;
            if (done1 !== (c == 9) || done3 !== (c == 25)) begin
                errors++;
                $display("FAIL reset_rescan_done c=%0d: done=%b/%b, required %b/%b",
                         c, done1, done3, c == 9, c == 25);
            end
            if (c == 9) begin
                exp_data1 = a & mask;
                checks++;
                if (data1 !== exp_data1) begin
                    errors++;
                    $display("FAIL reset_rescan_data1: data=%h, required %h", data1, exp_data1);
                end
            end
            if (c == 25) begin
                exp_data3 = a & mask;
                checks++;
                if (data3 !== exp_data3) begin
                    errors++;
                    $display("FAIL reset_rescan_data3: data=%h, required %h", data3, exp_data3);
                end
            end
            tick();
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        mask = 8'hFF; a = 8'h5A;
        start = 1'b1;
        for (int c = 1; c <= 52; c++) begin
            tick();
            checks++;
            if (done1 !== (c % 10 == 9) || busy1 !== (c % 10 >= 1 && c % 10 <= 8)
                || done3 !== (c % 26 == 25) || busy3 !== (c % 26 >= 1 && c % 26 <= 24)) begin
                errors++;
                $display("FAIL b2b_timing c=%0d: done=%b/%b busy=%b/%b", c, done1, done3,
                         busy1, busy3);
            end
            if (done1 === 1'b1 || done3 === 1'b1) begin
                checks++;
                if ((done1 && data1 !== 8'h5A) || (done3 && data3 !== 8'h5A)) begin
                    errors++;
                    $display("FAIL b2b_data c=%0d: data=%h/%h, required 5a", c, data1, data3);
                end
            end
        end
        exp_data1 = 8'h5A;
        exp_data3 = 8'h5A;
        wait_idle();
    endtask

    task automatic test_mid_change();
        mask = 8'hFF; a = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 5) a = 8'hFF;
            if (c == 9) begin
                exp_data1 = exp_change(1, 5, mask);
                checks++;
                if (done1 !== 1'b1 || data1 !== exp_data1) begin
                    errors++;
                    $display("FAIL mid_change_dut1: done=%b data=%h, required 1 %h",
                             done1, data1, exp_data1);
                end
            end
            if (c == 25) begin
                exp_data3 = exp_change(3, 5, mask);
                checks++;
                if (done3 !== 1'b1 || data3 !== exp_data3) begin
                    errors++;
                    $display("FAIL mid_change_dut3: done=%b data=%h, required 1 %h",
                             done3, data3, exp_data3);
                end
            end
            tick();
        end
        wait_idle();
    endtask

    task automatic test_random();
        int         ab;
        logic [2:0] ch;
        for (int it = 0; it < 10; it++) begin
            mask = 8'($urandom);
            a    = 8'($urandom);
            ab   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 99;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 1; c <= 31; c++) begin
                abort = (c == ab);
                if (c <= 8 && c <= ab) begin
                    ch = 3'(c - 1);
                    checks++;
                    if (sel1 !== ch || en1 !== mask[ch]) begin
                        errors++;
                        $display("FAIL rand_sel it=%0d c=%0d: sel=%0d en=%b, required %0d %b",
                                 it, c, sel1, en1, ch, mask[ch]);
                    end
                end
                checks++;
                if (done1 !== (c == 9 && ab >= 9) || done3 !== (c == 25 && ab >= 25)) begin
                    errors++;
                    $display("FAIL rand_done it=%0d c=%0d ab=%0d: done=%b/%b, required %b/%b",
                             it, c, ab, done1, done3, c == 9 && ab >= 9, c == 25 && ab >= 25);
                end
                if (c == 9 && ab >= 9) exp_data1 = a & mask;
                if (c == 25 && ab >= 25) exp_data3 = a & mask;
                tick();
            end
            abort = 1'b0;
            checks++;
            if (busy1 !== 1'b0 || busy3 !== 1'b0 || data1 !== exp_data1 || data3 !== exp_data3) begin
                errors++;
                $display("FAIL rand_end it=%0d ab=%0d: busy=%b/%b data=%h/%h, required 0/0 %h/%h",
                         it, ab, busy1, busy3, data1, data3, exp_data1, exp_data3);
            end
            wait_idle();
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_settle3();
        test_abort();
        test_abort_priority();
        test_reset_mid();
        test_back_to_back();
        test_mid_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, meaning cycles each channel is held before capture; legal range 1..15.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port start, input, 1, scan request, sampled only in IDLE.
REQ-005 The module SHALL have port abort, input, 1, synchronous scan cancel.
REQ-006 The module SHALL have port mask, input, 8, per-channel enable; latched on accepted start.
REQ-007 The module SHALL have port sel, output, 3, channel select to the 8:1 mux s input.
REQ-008 The module SHALL have port mux_en, output, 1, drives the 8:1 mux en input.
REQ-009 The module SHALL have port mux_y, input, 1, the 8:1 mux y output.
REQ-010 The module SHALL have port busy, output, 1, high while in SCAN.
REQ-011 The module SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 The module SHALL have port data, output, 8, assembled word; bit n = sample of channel n.

Function
REQ-013 The FSM SHALL have states IDLE, SCAN, DONE, and no others.
REQ-014 In IDLE with start=1 and abort=0 at an edge, the block SHALL latch mask, clear the channel counter ch and hold counter cnt to 0, clear the capture register, and enter SCAN.
REQ-015 In IDLE, sel SHALL be 0 and mux_en SHALL be 0.
REQ-016 In SCAN, sel SHALL equal ch and mux_en SHALL equal latched mask[ch], both registered and stable for SETTLE cycles per channel.
REQ-017 In SCAN, each edge SHALL increment cnt; on the edge where cnt==SETTLE-1, the block SHALL write mux_y into capture bit ch, clear cnt, and increment ch.
REQ-018 On the capture edge with ch==7, the block SHALL enter DONE; ch SHALL NOT wrap within a scan.
REQ-019 On entry to DONE, data SHALL load the full capture register, including the channel-7 bit.
REQ-020 done SHALL be 1 for exactly the one DONE cycle, with sel=0 and mux_en=0; the next state SHALL be IDLE.
REQ-021 Latency SHALL be: start accepted at edge k means done is high in cycle k+1+8*SETTLE.
REQ-022 Masked channels (mask bit 0) SHALL still consume SETTLE cycles, with mux_en=0; the captured bit is whatever mux_y returns, which is 0 for a compliant mux.
REQ-023 start SHALL be ignored in SCAN and DONE; start held high continuously SHALL re-trigger on the first IDLE cycle after DONE.
REQ-024 abort=1 in SCAN or DONE SHALL force IDLE at the next edge, with no done pulse and data unchanged.
REQ-025 abort=1 in IDLE SHALL take priority over start; no scan begins.
REQ-026 data SHALL change only on DONE entry, and SHALL hold its value between scans.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, ch=0, cnt=0, sel=0, mux_en=0, busy=0, done=0, data=8'h00, and capture register = 0.
REQ-028 Reset asserted mid-SCAN SHALL discard the scan, with no done pulse; operation SHALL resume only on a new start after rst_n=1.

Verification
REQ-029 SETTLE=1, mask=8'hFF, mux a=8'hA5, pulse start at cycle 0 -> sel steps 0..7 in cycles 1..8, done=1 in cycle 9, data=8'hA5.
REQ-030 SETTLE=3, mask=8'h0F, a=8'hFF -> each sel value is held 3 cycles, mux_en=0 for channels 4..7, done in cycle 25, data=8'h0F.
REQ-031 SETTLE=1, abort asserted in cycle 4 of a scan with a=8'h3C -> IDLE in the next cycle, no done, data keeps its previous value.
REQ-032 SETTLE=1, rst_n pulsed low mid-scan -> all outputs are 0 immediately, with no done; a new start then yields a correct data value.
REQ-033 start held high continuously, a=8'h5A -> back-to-back scans, done every 10 cycles, data=8'h5A each time, busy low only in DONE/IDLE cycles.
REQ-034 a changed from 8'h00 to 8'hFF during a scan after channel 3 has been captured -> data=8'hF0.
